// File: rtl/mem_lsu_axi.sv
// mem_lsu_axi: single-outstanding load/store/fetch unit for an AXI4-Lite master.
// Aligns store lanes, extends load data and reports misalignment and bus errors.
module mem_lsu_axi #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [1:0]          req_op,
    input  logic [1:0]          req_size,
    input  logic                req_signed,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_data,
    output logic [1:0]          rsp_err,
    output logic                rsp_fetch,
    output logic                busy,
    output logic                awvalid,
    input  logic                awready,
    output logic [ADDR_W-1:0]   awaddr,
    output logic [2:0]          awprot,
    output logic                wvalid,
    input  logic                wready,
    output logic [DATA_W-1:0]   wdata,
    output logic [DATA_W/8-1:0] wstrb,
    input  logic                bvalid,
    output logic                bready,
    input  logic [1:0]          bresp,
    output logic                arvalid,
    input  logic                arready,
    output logic [ADDR_W-1:0]   araddr,
    output logic [2:0]          arprot,
    input  logic                rvalid,
    output logic                rready,
    input  logic [DATA_W-1:0]   rdata,
    input  logic [1:0]          rresp
);
    localparam int STRB_W = DATA_W / 8;
    localparam int OFF = $clog2(STRB_W);
    localparam logic [ADDR_W-1:0] AMASK = ~ADDR_W'(STRB_W - 1);

    typedef enum logic [2:0] {IDLE, WADDR, WRESP, RADDR, RDATA, RESP} state_t;
    state_t state, state_nx;

    logic [OFF-1:0]    lane_q;
    logic [1:0]        size_q;
    logic              sgn_q;
    logic              aw_done, w_done;

    logic              accept, is_store, is_fetch, misaligned;
    logic [1:0]        eff_size;
    logic [OFF-1:0]    lane;
    logic [STRB_W-1:0] strb_base;
    logic              aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic [DATA_W-1:0] sh, ld_mask, ld_val;
    logic              ld_neg;

    assign accept   = req_valid && req_ready;
    assign is_store = (req_op == 2'b00);
    assign is_fetch = req_op[1];
    assign eff_size = is_fetch ? 2'b10 : req_size;
    assign lane     = req_addr[OFF-1:0];
    assign aw_hs    = awvalid && awready;
    assign w_hs     = wvalid && wready;
    assign b_hs     = bvalid && bready;
    assign ar_hs    = arvalid && arready;
    assign r_hs     = rvalid && rready;
    assign busy     = (state != IDLE);

    // alignment check and base byte-enable pattern for the request size
    always_comb begin
        misaligned = 1'b0;
        strb_base  = '0;
        unique case (eff_size)
            2'b00: strb_base = STRB_W'(8'h01);
            2'b01: begin
                misaligned = req_addr[0];
                strb_base  = STRB_W'(8'h03);
            end
            2'b10: begin
                misaligned = (req_addr[1:0] != 2'b00);
                strb_base  = STRB_W'(8'h0F);
            end
            2'b11: begin
                misaligned = (DATA_W == 32) || (req_addr[2:0] != 3'b000);
                strb_base  = STRB_W'(8'hFF);
            end
        endcase
    end

    // shift the read beat down to the lane, then truncate and extend
    always_comb begin
        sh      = rdata >> {lane_q, 3'b000};
        ld_mask = '1;
        ld_neg  = sh[DATA_W-1];
        unique case (size_q)
            2'b00: begin ld_mask = DATA_W'(8'hFF);        ld_neg = sh[7];  end
            2'b01: begin ld_mask = DATA_W'(16'hFFFF);     ld_neg = sh[15]; end
            2'b10: begin ld_mask = DATA_W'(32'hFFFF_FFFF); ld_neg = sh[31]; end
            2'b11: begin ld_mask = '1; ld_neg = sh[DATA_W-1]; end
        endcase
        ld_val = (sh & ld_mask) | ({DATA_W{sgn_q && ld_neg}} & ~ld_mask);
    end

    // state register
    always_ff @(posedge clock) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nx;
    end

    // next-state logic
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (accept) begin
                if (misaligned)    state_nx = RESP;
                else if (is_store) state_nx = WADDR;
                else               state_nx = RADDR;
            end
            WADDR: if ((aw_done || aw_hs) && (w_done || w_hs))
                state_nx = (aw_hs && w_hs && bvalid) ? RESP : WRESP;
            WRESP: if (bvalid) state_nx = RESP;
            RADDR: if (ar_hs) state_nx = rvalid ? RESP : RDATA;
            RDATA: if (rvalid) state_nx = RESP;
            RESP:  if (rsp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // combinational ready outputs decoded from state
    always_comb begin
        req_ready = resetn && (state == IDLE);
        bready    = (state == WRESP) || ((state == WADDR) && aw_hs && w_hs);
        rready    = (state == RADDR) || (state == RDATA);
    end

    // registered channel valids, payloads and response fields
    always_ff @(posedge clock) begin
        if (!resetn) begin
            awvalid   <= 1'b0;
            wvalid    <= 1'b0;
            arvalid   <= 1'b0;
            awaddr    <= '0;
            awprot    <= 3'b000;
            wdata     <= '0;
            wstrb     <= '0;
            araddr    <= '0;
            arprot    <= 3'b000;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 2'b00;
            rsp_fetch <= 1'b0;
            lane_q    <= '0;
            size_q    <= 2'b00;
            sgn_q     <= 1'b0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
        end else begin
            rsp_valid <= (state_nx == RESP);
            if (accept) begin
                lane_q    <= lane;
                size_q    <= eff_size;
                sgn_q     <= req_signed && !is_fetch;
                rsp_fetch <= is_fetch;
                rsp_err   <= misaligned ? 2'b01 : 2'b00;
                rsp_data  <= '0;
                aw_done   <= 1'b0;
                w_done    <= 1'b0;
                if (!misaligned && is_store) begin
                    awvalid <= 1'b1;
                    wvalid  <= 1'b1;
                    awaddr  <= req_addr & AMASK;
                    awprot  <= 3'b000;
                    wdata   <= req_wdata << {lane, 3'b000};
                    wstrb   <= strb_base << lane;
                end
                if (!misaligned && !is_store) begin
                    arvalid <= 1'b1;
                    araddr  <= req_addr & AMASK;
                    arprot  <= is_fetch ? 3'b100 : 3'b000;
                end
            end
            if (aw_hs) begin
                awvalid <= 1'b0;
                aw_done <= 1'b1;
            end
            if (w_hs) begin
                wvalid <= 1'b0;
                w_done <= 1'b1;
            end
            if (ar_hs) arvalid <= 1'b0;
            if (b_hs) rsp_err <= bresp[1] ? 2'b10 : 2'b00;
            if (r_hs) begin
                rsp_err  <= rresp[1] ? 2'b10 : 2'b00;
                rsp_data <= rresp[1] ? '0 : ld_val;
            end
        end
    end
endmodule

// File: tb/tb_mem_lsu_axi.sv
// tb_mem_lsu_axi: directed checks of mem_lsu_axi on 32- and 64-bit buses.
// Slave responses are driven cycle by cycle with hand-computed expectations.
module tb_mem_lsu_axi;
    logic        clock = 1'b0;
    logic        resetn;
    int          total = 0;
    int          bad = 0;

    // 32-bit instance signals
    logic        req_valid, req_ready, req_signed;
    logic [1:0]  req_op, req_size;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_ready, rsp_fetch, busy;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_err;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] awaddr, araddr, wdata, rdata;
    logic [2:0]  awprot, arprot;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;

    // 64-bit instance signals (always-ready slave)
    logic        q_req_valid, q_req_ready, q_req_signed;
    logic [1:0]  q_req_op, q_req_size;
    logic [31:0] q_req_addr;
    logic [63:0] q_req_wdata, q_rdata, q_rsp_data, q_wdata;
    logic        q_rsp_valid, q_rsp_fetch, q_busy;
    logic [1:0]  q_rsp_err;
    logic        q_awvalid, q_wvalid, q_bready, q_arvalid, q_rready;
    logic [31:0] q_awaddr, q_araddr;
    logic [2:0]  q_awprot, q_arprot;
    logic [7:0]  q_wstrb;

    always #5 clock = ~clock;

    mem_lsu_axi #(.DATA_W(32), .ADDR_W(32)) u32 (
        .clock(clock), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_size(req_size),
        .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_err(rsp_err),
        .rsp_fetch(rsp_fetch), .busy(busy),
        .awvalid(awvalid), .awready(awready),
        .awaddr(awaddr), .awprot(awprot),
        .wvalid(wvalid), .wready(wready),
        .wdata(wdata), .wstrb(wstrb),
        .bvalid(bvalid), .bready(bready), .bresp(bresp),
        .arvalid(arvalid), .arready(arready),
        .araddr(araddr), .arprot(arprot),
        .rvalid(rvalid), .rready(rready),
        .rdata(rdata), .rresp(rresp)
    );

    mem_lsu_axi #(.DATA_W(64), .ADDR_W(32)) u64 (
        .clock(clock), .resetn(resetn),
        .req_valid(q_req_valid), .req_ready(q_req_ready),
        .req_op(q_req_op), .req_size(q_req_size),
        .req_signed(q_req_signed), .req_addr(q_req_addr),
        .req_wdata(q_req_wdata),
        .rsp_valid(q_rsp_valid), .rsp_ready(1'b1),
        .rsp_data(q_rsp_data), .rsp_err(q_rsp_err),
        .rsp_fetch(q_rsp_fetch), .busy(q_busy),
        .awvalid(q_awvalid), .awready(1'b1),
        .awaddr(q_awaddr), .awprot(q_awprot),
        .wvalid(q_wvalid), .wready(1'b1),
        .wdata(q_wdata), .wstrb(q_wstrb),
        .bvalid(1'b1), .bready(q_bready), .bresp(2'b00),
        .arvalid(q_arvalid), .arready(1'b1),
        .araddr(q_araddr), .arprot(q_arprot),
        .rvalid(1'b1), .rready(q_rready),
        .rdata(q_rdata), .rresp(2'b00)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic req32(input logic [1:0] op, input logic [1:0] size,
                         input logic sgn, input logic [31:0] addr,
                         input logic [31:0] wd);
        req_valid  = 1'b1;
        req_op     = op;
        req_size   = size;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wd;
    endtask

    task automatic load64(input string tag, input logic [1:0] size,
                          input logic sgn, input logic [31:0] addr,
                          input logic [63:0] beat, input logic [1:0] err,
                          input logic [63:0] exp);
        q_req_valid  = 1'b1;
        q_req_op     = 2'b01;
        q_req_size   = size;
        q_req_signed = sgn;
        q_req_addr   = addr;
        q_rdata      = beat;
        tick();
        q_req_valid = 1'b0;
        if (err == 2'b00) tick();
        chk({tag, "_valid"}, q_rsp_valid, 1'b1);
        chk({tag, "_err"}, q_rsp_err, err);
        if (err == 2'b00) chk({tag, "_data"}, q_rsp_data, exp);
        tick();
    endtask

    initial begin
        logic [31:0] held;
        resetn = 1'b0;
        req_valid = 0; req_op = 0; req_size = 0; req_signed = 0;
        req_addr = 0; req_wdata = 0; rsp_ready = 0;
        awready = 0; wready = 0; bvalid = 0; bresp = 0;
        arready = 0; rvalid = 0; rdata = 0; rresp = 0;
        q_req_valid = 0; q_req_op = 0; q_req_size = 0; q_req_signed = 0;
        q_req_addr = 0; q_req_wdata = 0; q_rdata = 0;
        tick();
        tick();
        chk("rst_awvalid", awvalid, 1'b0);
        chk("rst_arvalid", arvalid, 1'b0);
        chk("rst_wvalid", wvalid, 1'b0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_err", rsp_err, 2'b00);
        chk("rst_req_ready", req_ready, 1'b0);
        chk("rst_ready_bus", {bready, rready}, 2'b00);
        chk("rst_awaddr", awaddr, 32'h0);
        resetn = 1'b1;
        tick();
        chk("rel_req_ready", req_ready, 1'b1);
        chk("rel_busy", busy, 1'b0);

        // store byte to lane 3 with always-ready slave and early B
        req32(2'b00, 2'b00, 1'b0, 32'h0000_1003, 32'h0000_00A5);
        awready = 1; wready = 1; bvalid = 1; bresp = 2'b00;
        tick();
        req_valid = 0;
        chk("sb_awvalid", awvalid, 1'b1);
        chk("sb_wvalid", wvalid, 1'b1);
        chk("sb_awaddr", awaddr, 32'h0000_1000);
        chk("sb_wdata", wdata, 32'hA500_0000);
        chk("sb_wstrb", wstrb, 4'b1000);
        chk("sb_awprot", awprot, 3'b000);
        chk("sb_bready", bready, 1'b1);
        tick();
        chk("sb_rsp_valid", rsp_valid, 1'b1);
        chk("sb_rsp_err", rsp_err, 2'b00);
        chk("sb_valids_low", {awvalid, wvalid}, 2'b00);
        bvalid = 0; awready = 0; wready = 0; rsp_ready = 1;
        tick();
        chk("sb_rsp_done", rsp_valid, 1'b0);

        // misaligned word load, then dword on a 32-bit bus
        req32(2'b01, 2'b10, 1'b0, 32'h0000_0002, 32'h0);
        tick();
        req_valid = 0;
        chk("mis_w_valid", rsp_valid, 1'b1);
        chk("mis_w_err", rsp_err, 2'b01);
        chk("mis_w_arvalid", arvalid, 1'b0);
        tick();
        chk("mis_w_done", rsp_valid, 1'b0);
        req32(2'b01, 2'b11, 1'b0, 32'h0000_0000, 32'h0);
        tick();
        req_valid = 0;
        chk("mis_d_valid", rsp_valid, 1'b1);
        chk("mis_d_err", rsp_err, 2'b01);
        chk("mis_d_arvalid", arvalid, 1'b0);
        tick();
        rsp_ready = 0;

        // store word: AW accepted early, W delayed, B slave error
        req32(2'b00, 2'b10, 1'b0, 32'h0000_2000, 32'h1122_3344);
        awready = 1;
        tick();
        req_valid = 0;
        chk("sw_awvalid", awvalid, 1'b1);
        chk("sw_wstrb", wstrb, 4'b1111);
        tick();
        chk("sw_aw_drop", awvalid, 1'b0);
        chk("sw_w_hold0", wvalid, 1'b1);
        tick();
        chk("sw_w_hold1", wvalid, 1'b1);
        tick();
        chk("sw_w_hold2", wvalid, 1'b1);
        chk("sw_wdata", wdata, 32'h1122_3344);
        awready = 0; wready = 1;
        tick();
        wready = 0;
        chk("sw_w_drop", wvalid, 1'b0);
        chk("sw_no_rsp", rsp_valid, 1'b0);
        bvalid = 1; bresp = 2'b10;
        chk("sw_bready", bready, 1'b1);
        tick();
        bvalid = 0; bresp = 0;
        chk("sw_rsp_valid", rsp_valid, 1'b1);
        chk("sw_rsp_err", rsp_err, 2'b10);
        rsp_ready = 1;
        tick();
        rsp_ready = 0;

        // fetch with slow AR and R, then a stalled response
        req32(2'b10, 2'b00, 1'b1, 32'h0000_0100, 32'h0);
        tick();
        req_valid = 0;
        chk("f_arvalid", arvalid, 1'b1);
        chk("f_arprot", arprot, 3'b100);
        chk("f_araddr", araddr, 32'h0000_0100);
        tick();
        chk("f_ar_hold", arvalid, 1'b1);
        arready = 1;
        tick();
        arready = 0;
        chk("f_ar_drop", arvalid, 1'b0);
        chk("f_rready", rready, 1'b1);
        tick();
        tick();
        rvalid = 1; rdata = 32'hDEAD_BEEF; rresp = 0;
        tick();
        rvalid = 0; rdata = 0;
        chk("f_rsp_fetch", rsp_fetch, 1'b1);
        chk("f_rsp_err", rsp_err, 2'b00);
        held = rsp_data;
        chk("f_rsp_data", held, 32'hDEAD_BEEF);
        for (int i = 0; i < 4; i++) begin
            chk("f_stall_valid", rsp_valid, 1'b1);
            chk("f_stall_data", rsp_data, 32'hDEAD_BEEF);
            tick();
        end
        rsp_ready = 1;
        tick();
        chk("f_done", rsp_valid, 1'b0);

        // signed byte load from lane 1, best-case latency
        req32(2'b01, 2'b00, 1'b1, 32'h0000_3001, 32'h0);
        arready = 1; rvalid = 1; rdata = 32'h0000_8000;
        tick();
        req_valid = 0;
        chk("lb_no_rsp", rsp_valid, 1'b0);
        tick();
        chk("lb_rsp_valid", rsp_valid, 1'b1);
        chk("lb_rsp_data", rsp_data, 32'hFFFF_FF80);
        tick();

        // load word with slave error returns zero data
        req32(2'b01, 2'b10, 1'b0, 32'h0000_0010, 32'h0);
        rdata = 32'h5555_5555; rresp = 2'b10;
        tick();
        req_valid = 0;
        tick();
        chk("le_rsp_err", rsp_err, 2'b10);
        chk("le_rsp_data", rsp_data, 32'h0);
        rresp = 0; rvalid = 0;
        tick();

        // reset while in RDATA aborts, then a normal load
        req32(2'b01, 2'b10, 1'b0, 32'h0000_0040, 32'h0);
        tick();
        req_valid = 0;
        tick();
        arready = 0;
        chk("rr_busy", busy, 1'b1);
        chk("rr_in_rdata", {arvalid, rready}, 2'b01);
        resetn = 0;
        tick();
        chk("rr_busy_low", busy, 1'b0);
        chk("rr_valids", {awvalid, wvalid, arvalid, rsp_valid}, 4'b0000);
        chk("rr_rready", rready, 1'b0);
        resetn = 1;
        req32(2'b01, 2'b10, 1'b0, 32'h0000_0044, 32'h0);
        arready = 1; rvalid = 1; rdata = 32'h1234_5678;
        tick();
        req_valid = 0;
        tick();
        chk("rr_ld_valid", rsp_valid, 1'b1);
        chk("rr_ld_data", rsp_data, 32'h1234_5678);
        arready = 0; rvalid = 0;
        tick();

        // 64-bit bus loads
        load64("h64s", 2'b01, 1'b1, 32'h0000_2006,
               64'h8123_0000_0000_0000, 2'b00, 64'hFFFF_FFFF_FFFF_8123);
        load64("h64u", 2'b01, 1'b0, 32'h0000_2006,
               64'h8123_0000_0000_0000, 2'b00, 64'h0000_0000_0000_8123);
        load64("d64", 2'b11, 1'b1, 32'h0000_0008,
               64'h0123_4567_89AB_CDEF, 2'b00, 64'h0123_4567_89AB_CDEF);
        load64("w64s", 2'b10, 1'b1, 32'h0000_0004,
               64'h8000_0001_0000_0000, 2'b00, 64'hFFFF_FFFF_8000_0001);
        load64("d64mis", 2'b11, 1'b0, 32'h0000_0004,
               64'h0, 2'b01, 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
